// File: rtl/input_cond.sv
// input_cond: debounces a pushbutton and the left mouse button, clamps mouse x/y.
// Ports: clk, rst (sync, active-high); button_in, mouse_left_in (raw levels);
//   xpos_in, ypos_in (12-bit raw); button_out (press pulse);
//   mouse_left_out (pulse or level); xpos_out, ypos_out (clamped, registered).
// Option: define CLICK_PULSE_EN to make mouse_left_out a press pulse
//   instead of the debounced level.
module input_cond #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int XMAX            = 1023,
  parameter int YMAX            = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button_in,
  input  logic        mouse_left_in,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  output logic        button_out,
  output logic        mouse_left_out,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value after which one more differing clock accepts the change.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0]   XM   = 12'(XMAX);
  localparam logic [11:0]   YM   = 12'(YMAX);

  // Channel 0 = pushbutton, channel 1 = left mouse button.
  logic [1:0]    w_raw;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [CW-1:0] r_cnt [2];
  logic          r_btn;
  logic          r_click;
  logic [11:0]   r_x;
  logic [11:0]   r_y;

  assign w_raw = {mouse_left_in, button_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
      r_btn      <= 1'b0;
      r_click    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_stable[i] <= r_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
      r_stable_d <= r_stable;
      r_btn      <= r_stable[0] & ~r_stable_d[0];
`ifdef CLICK_PULSE_EN
      r_click    <= r_stable[1] & ~r_stable_d[1];
`else
      r_click    <= r_stable[1];
`endif
      r_x <= (xpos_in > XM) ? XM : xpos_in;
      r_y <= (ypos_in > YM) ? YM : ypos_in;
    end
  end

  assign button_out     = r_btn;
  assign mouse_left_out = r_click;
  assign xpos_out       = r_x;
  assign ypos_out       = r_y;

endmodule
